// File: rtl/nr_div_sequencer.sv
// Folded Newton-Raphson divide controller: refines x ~ 1/divisor ITERATIONS times on one
// shared external 24x24 multiplier, then forms quotient = x * dividend.
module nr_div_sequencer #(
  parameter int unsigned ITERATIONS = 12,
  parameter int unsigned MUL_LAT    = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        ready_o,
  input  logic [23:0] pre_dividend_i,
  input  logic [23:0] pre_divisor_i,
  input  logic [23:0] initial_guess_i,
  output logic [23:0] mul_x_o,
  output logic [23:0] mul_y_o,
  input  logic [23:0] mul_result_i,
  output logic [23:0] quotient_o,
  output logic        done_o,
  output logic        div_by_zero_o,
  output logic        busy_o
);

  if (ITERATIONS == 0 || ITERATIONS > 15) begin : gen_bad_iterations
    $error("nr_div_sequencer: ITERATIONS must be in 1..15");
  end
  if (MUL_LAT == 0 || MUL_LAT > 4) begin : gen_bad_mul_lat
    $error("nr_div_sequencer: MUL_LAT must be in 1..4");
  end

  localparam logic [3:0] LastIter = 4'(ITERATIONS - 1);
  localparam logic [1:0] LastLat  = 2'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMulA,
    StMulB,
    StFinal,
    StZero,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] x_q, x_d;
  logic [23:0] d_q, d_d;
  logic [23:0] dd_q, dd_d;
  logic [3:0]  iter_q, iter_d;
  logic [1:0]  lat_q, lat_d;
  logic [23:0] mul_x_q, mul_x_d;
  logic [23:0] mul_y_q, mul_y_d;
  logic [23:0] quot_q, quot_d;
  logic        dbz_q, dbz_d;
  logic        op_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      x_q     <= '0;
      d_q     <= '0;
      dd_q    <= '0;
      iter_q  <= '0;
      lat_q   <= '0;
      mul_x_q <= '0;
      mul_y_q <= '0;
      quot_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      d_q     <= d_d;
      dd_q    <= dd_d;
      iter_q  <= iter_d;
      lat_q   <= lat_d;
      mul_x_q <= mul_x_d;
      mul_y_q <= mul_y_d;
      quot_q  <= quot_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    d_d     = d_q;
    dd_d    = dd_q;
    iter_d  = iter_q;
    lat_d   = lat_q;
    mul_x_d = mul_x_q;
    mul_y_d = mul_y_q;
    quot_d  = quot_q;
    dbz_d   = dbz_q;
    op_last = (lat_q == LastLat);

    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) state_d = StIdle;
        if (start_i) begin
          d_d    = pre_divisor_i;
          dd_d   = pre_dividend_i;
          x_d    = initial_guess_i;
          iter_d = '0;
          lat_d  = '0;
          dbz_d  = 1'b0;
          if (pre_divisor_i == '0) begin
            state_d = StZero;
          end else begin
            state_d = StMulA;
            mul_x_d = initial_guess_i;
            mul_y_d = pre_divisor_i;
          end
        end
      end
      StMulA: begin
        if (op_last) begin
          lat_d   = '0;
          // s = 2 - x*d in the truncated format; wraps, so p == 0 yields s == 0
          mul_x_d = 24'(25'h1000000 - {1'b0, mul_result_i});
          mul_y_d = x_q;
          state_d = StMulB;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StMulB: begin
        if (op_last) begin
          lat_d   = '0;
          x_d     = mul_result_i;
          iter_d  = iter_q + 4'd1;
          mul_x_d = mul_result_i;
          if (iter_q == LastIter) begin
            mul_y_d = dd_q;
            state_d = StFinal;
          end else begin
            mul_y_d = d_q;
            state_d = StMulA;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StFinal: begin
        if (op_last) begin
          lat_d   = '0;
          quot_d  = mul_result_i;
          state_d = StDone;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StZero: begin
        quot_d  = 24'hFFFFFF;
        dbz_d   = 1'b1;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ready_o       = (state_q == StIdle) || (state_q == StDone);
  assign busy_o        = ~ready_o;
  assign done_o        = (state_q == StDone);
  assign mul_x_o       = mul_x_q;
  assign mul_y_o       = mul_y_q;
  assign quotient_o    = quot_q;
  assign div_by_zero_o = dbz_q;

endmodule
